siso_shift_sequencer: RTL and testbench
=======================================

Name: siso_shift_sequencer

Overview:
- Sequencer for the team's WIDTH-bit serial-in/serial-out shift register, which has Serial_IN, Load (1 = shift, 0 = hold) and CLK.
- Accepts a parallel word over a valid/ready handshake and feeds it into the register LSB-first, one Load pulse per bit.
- Shift rate is set by a prescaler. After WIDTH shifts the register's parallel outputs hold the word, and the sequencer pulses Done.
- Sits between a parallel producer and the shift-register datapath.

Parameters:
- WIDTH, 4, number of bits per word; equals the shift register depth; minimum 2.
- DIV, 1, CLK cycles per shift step; minimum 1; DIV=1 shifts every cycle.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- Data_IN  input  WIDTH  parallel word to serialise.
- Data_Valid  input  1  producer has a word on Data_IN.
- Data_Ready  output  1  sequencer can accept a word.
- Hold  input  1  pauses shifting while high.
- Shift_EN  output  1  drives the shift register's Load input.
- Serial_Data  output  1  drives the shift register's Serial_IN input.
- Busy  output  1  high while a word is in flight (SHIFT or DONE).
- Done  output  1  one-cycle pulse after the last shift.
- Bit_Count  output  clog2(WIDTH+1)  number of bits shifted in the current word.

Behaviour:
- Reset: one clock, CLK; reset RST_N is asynchronous and active-low. While RST_N=0:
  - state=IDLE; shadow register, prescaler and Bit_Count are 0.
  - Shift_EN=0, Serial_Data=0, Done=0, Busy=0, Data_Ready=1.
  - Reset mid-word abandons the word with no Done. The shift register contents are not touched.
- FSM states: IDLE, SHIFT, DONE. Outputs depend only on registered state, except Shift_EN, which is also gated by Hold.
- IDLE:
  - Data_Ready=1, Busy=0.
  - Acceptance is Data_Valid&&Data_Ready at a rising edge. On acceptance: shadow<=Data_IN, prescaler<=0, Bit_Count<=0, next state SHIFT.
  - Data_Valid while not in IDLE is ignored and is not latched.
- SHIFT:
  - Data_Ready=0, Busy=1, Serial_Data=shadow[0].
  - Prescaler counts 0..DIV-1 and wraps; it freezes while Hold=1.
  - Shift_EN = (prescaler==DIV-1) && !Hold.
  - On a Shift_EN cycle: shadow shifts right by 1 (MSB filled with 0) and Bit_Count increments.
  - On a Shift_EN cycle with Bit_Count==WIDTH-1: next state DONE, and Bit_Count becomes WIDTH.
- DONE:
  - Done=1, Busy=1, Data_Ready=0, Shift_EN=0.
  - Next state IDLE; Bit_Count is held at WIDTH until the next acceptance.
- Latency (DIV=1, Hold=0), with acceptance at edge t0:
  - Shift_EN is high for WIDTH consecutive cycles following t0.
  - Done is high in the next cycle.
  - Data_Ready returns one cycle later, giving a throughput of one word per WIDTH+2 cycles.
  - For general DIV, the first Shift_EN occurs DIV cycles after acceptance.
- Bit ordering: Data_IN[0] is shifted first. After the WIDTH-th shift the register's q[i] equals Data_IN[i].
- Hold:
  - Hold asserted on the same cycle as a Shift_EN would occur suppresses that shift, and the bit is retried after release with the prescaler still at DIV-1.
  - Hold in IDLE or DONE has no effect.
- Serial_Data is stable for the whole cycle in which Shift_EN=1. Serial_Data is 0 in IDLE and DONE.
- Elaboration checks: WIDTH<2 or DIV<1 is a fatal error.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - a clog2 function for the prescaler and Bit_Count widths.
- One natural sub-module: shift_prescaler (DIV-modulo counter with freeze input and terminal-count output). Everything else stays in siso_shift_sequencer.
- Integration: the top level instantiates the existing shift register beside this block. Connections are Shift_EN to Load, Serial_Data to Serial_IN, and the same CLK.

Test Plan:
- Basic word: reset, WIDTH=4, DIV=1, Data_IN=4'b1011 with Data_Valid for 1 cycle. Required response:
  - Shift_EN high for exactly 4 cycles; Serial_Data sequence 1,1,0,1.
  - Done pulse one cycle later; the attached register then shows q=4'b1011; Bit_Count=4.
- Prescaler: DIV=3, Data_IN=4'b0110. Required response:
  - Shift_EN pulses every 3rd cycle, first pulse 3 cycles after acceptance.
  - Done arrives 13 cycles after acceptance; q=4'b0110.
- Hold: DIV=1, Data_IN=4'b1001, Hold=1 for 5 cycles after the 2nd shift. Required response:
  - No Shift_EN during Hold; Bit_Count stays 2.
  - Remaining bits 0,1 follow after release; q=4'b1001.
- Handshake: keep Data_Valid=1 continuously with words 4'hA then 4'h5. Required response:
  - Second word is accepted only on the cycle after Done, when Data_Ready=1.
  - Back-to-back interval is 6 cycles; q=4'h5 at the end.
- Reset mid-word: assert RST_N=0 asynchronously after the 2nd shift (not aligned to CLK). Required response:
  - Shift_EN, Busy and Done go 0 immediately; Data_Ready=1.
  - No Done pulse; a fresh word after release completes normally.
- Ignore while busy: pulse Data_Valid with 4'hF during SHIFT of 4'h3. Required response:
  - 4'hF is not latched; the output sequence is 1,1,0,0; q=4'h3.

Source files
------------

// File: rtl/siso_shift_sequencer_pkg.sv
// Shared definitions for the SISO shift sequencer: FSM encoding and a width helper.
package siso_shift_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/siso_shift_sequencer_if.sv
// Parallel word handshake between the producer and the shift sequencer.
interface siso_shift_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] Data_IN;
    logic             Data_Valid;
    logic             Data_Ready;

    modport master (output Data_IN, output Data_Valid, input  Data_Ready);
    modport slave  (input  Data_IN, input  Data_Valid, output Data_Ready);
endinterface

// File: rtl/siso_shift_sequencer_shift_prescaler.sv
// DIV-modulo step counter: freezes on request, flags the last count of each step.
module shift_prescaler
    import siso_shift_sequencer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic enable,
    input  logic freeze,
    output logic terminal
);
    localparam int CW = (DIV > 1) ? clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign terminal = (count == CW'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !freeze) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/siso_shift_sequencer.sv
// Serialises an accepted parallel word LSB-first into an external SISO shift register.
module siso_shift_sequencer
    import siso_shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    siso_shift_sequencer_if.slave        bus,
    input  logic                         Hold,
    output logic                         Shift_EN,
    output logic                         Serial_Data,
    output logic                         Busy,
    output logic                         Done,
    output logic [clog2(WIDTH+1)-1:0]    Bit_Count
);
    localparam int BCW = clog2(WIDTH + 1);

    if (WIDTH < 2 || DIV < 1) begin : g_bad_params
        $fatal(1, "siso_shift_sequencer: WIDTH must be >= 2 and DIV >= 1");
    end

    state_t           state, state_next;
    logic [WIDTH-1:0] shadow, shadow_next;
    logic [BCW-1:0]   bit_count, bit_count_next;
    logic             accept;
    logic             step;
    logic             in_shift;

    assign in_shift = (state == ST_SHIFT);
    assign accept   = bus.Data_Valid && bus.Data_Ready;

    shift_prescaler #(.DIV(DIV)) u_prescaler (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clear    (accept),
        .enable   (in_shift),
        .freeze   (Hold),
        .terminal (step)
    );

    // Hold is the only input allowed to reach an output combinationally.
    assign Shift_EN       = in_shift && step && !Hold;
    assign Serial_Data    = in_shift && shadow[0];
    assign bus.Data_Ready = (state == ST_IDLE);
    assign Busy           = (state != ST_IDLE);
    assign Done           = (state == ST_DONE);
    assign Bit_Count      = bit_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            shadow    <= '0;
            bit_count <= '0;
        end else begin
            state     <= state_next;
            shadow    <= shadow_next;
            bit_count <= bit_count_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        shadow_next    = shadow;
        bit_count_next = bit_count;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    shadow_next    = bus.Data_IN;
                    bit_count_next = '0;
                    state_next     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (Shift_EN) begin
                    shadow_next    = {1'b0, shadow[WIDTH-1:1]};
                    bit_count_next = bit_count + 1'b1;
                    if (bit_count == BCW'(WIDTH - 1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_siso_shift_sequencer.sv
// Directed bench: two sequencers (DIV=1, DIV=3) each driving a behavioural SISO register.
module tb_siso_shift_sequencer;
    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] exp_seq;    // serial bits, first bit out in the MSB position
        int               hold_after; // shifts completed before Hold goes high
        int               hold_len;   // Hold duration in cycles (0 = none)
        bit               inject;     // pulse Data_Valid with 4'hF during SHIFT
        int               exp_done;   // cycle after acceptance in which Done is high
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    siso_shift_sequencer_if #(.WIDTH(WIDTH)) bus1();
    siso_shift_sequencer_if #(.WIDTH(WIDTH)) bus3();

    logic       hold1 = 1'b0, hold3 = 1'b0;
    logic       se1, sd1, busy1, done1;
    logic       se3, sd3, busy3, done3;
    logic [2:0] bc1, bc3;

    siso_shift_sequencer #(.WIDTH(WIDTH), .DIV(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .bus(bus1), .Hold(hold1), .Shift_EN(se1),
        .Serial_Data(sd1), .Busy(busy1), .Done(done1), .Bit_Count(bc1)
    );

    siso_shift_sequencer #(.WIDTH(WIDTH), .DIV(3)) dut3 (
        .CLK(clk), .RST_N(rst_n), .bus(bus3), .Hold(hold3), .Shift_EN(se3),
        .Serial_Data(sd3), .Busy(busy3), .Done(done3), .Bit_Count(bc3)
    );

    // Behavioural shift registers: Load=1 shifts Serial_IN in at the MSB end; unaffected by reset.
    logic [WIDTH-1:0] q1 = '0, q3 = '0;
    always @(posedge clk) begin
        if (se1) q1 <= {sd1, q1[WIDTH-1:1]};
        if (se3) q3 <= {sd3, q3[WIDTH-1:1]};
    end

    // Acceptance log for the DIV=1 sequencer.
    int               cyc = 0;
    int               n_acc1 = 0;
    int               acc_cyc[$];
    logic [WIDTH-1:0] acc_dat[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus1.Data_Valid && bus1.Data_Ready) begin
            n_acc1 <= n_acc1 + 1;
            acc_cyc.push_back(cyc);
            acc_dat.push_back(bus1.Data_IN);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_word1(input vec_t v, output logic [WIDTH-1:0] seq, output int n_shift,
                             output int first_shift, output int done_cycle,
                             output int hold_err, output int accepts);
        int k;
        int hold_used;
        int acc0;
        seq = '0; n_shift = 0; first_shift = -1; done_cycle = -1;
        hold_err = 0; k = 0; hold_used = 0;
        @(negedge clk);
        acc0 = n_acc1;
        bus1.Data_IN    = v.data;
        bus1.Data_Valid = 1'b1;
        while (done_cycle < 0 && k < 60) begin
            @(posedge clk); #1;
            bus1.Data_Valid = v.inject && (k == 1);
            if (v.inject && k == 1) bus1.Data_IN = 4'hF;
            if (v.hold_len > 0 && n_shift == v.hold_after && hold_used < v.hold_len) begin
                hold1 = 1'b1;
                hold_used++;
            end else begin
                hold1 = 1'b0;
            end
            @(negedge clk);
            k++;
            if (se1) begin
                seq = {seq[WIDTH-2:0], sd1};
                n_shift++;
                if (first_shift < 0) first_shift = k;
            end
            if (hold1 && (se1 || bc1 != 3'(v.hold_after))) hold_err++;
            if (done1) done_cycle = k;
        end
        hold1 = 1'b0;
        bus1.Data_Valid = 1'b0;
        accepts = n_acc1 - acc0;
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        logic [WIDTH-1:0] seq;
        int n_shift, first_shift, done_cycle, hold_err, accepts;
        check({tag, "_ready_before"}, bus1.Data_Ready, 1);
        run_word1(v, seq, n_shift, first_shift, done_cycle, hold_err, accepts);
        check({tag, "_serial_seq"}, seq, v.exp_seq);
        check({tag, "_shift_count"}, n_shift, WIDTH);
        check({tag, "_first_shift"}, first_shift, 1);
        check({tag, "_done_cycle"}, done_cycle, v.exp_done);
        check({tag, "_bit_count_done"}, bc1, WIDTH);
        check({tag, "_reg_q"}, q1, v.data);
        check({tag, "_hold_violations"}, hold_err, 0);
        check({tag, "_accepts"}, accepts, 1);
        @(negedge clk);
        check({tag, "_ready_after"}, bus1.Data_Ready, 1);
        check({tag, "_busy_after"}, busy1, 0);
        check({tag, "_bit_count_held"}, bc1, WIDTH);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{data: 4'b1011, exp_seq: 4'b1101, hold_after: 0, hold_len: 0, inject: 0, exp_done: 5};
        vecs[1] = '{data: 4'b0001, exp_seq: 4'b1000, hold_after: 0, hold_len: 0, inject: 0, exp_done: 5};
        vecs[2] = '{data: 4'b1000, exp_seq: 4'b0001, hold_after: 0, hold_len: 0, inject: 0, exp_done: 5};
        vecs[3] = '{data: 4'b1111, exp_seq: 4'b1111, hold_after: 0, hold_len: 0, inject: 0, exp_done: 5};
        vecs[4] = '{data: 4'b0000, exp_seq: 4'b0000, hold_after: 0, hold_len: 0, inject: 0, exp_done: 5};
        vecs[5] = '{data: 4'b1001, exp_seq: 4'b1001, hold_after: 2, hold_len: 5, inject: 0, exp_done: 10};
        vecs[6] = '{data: 4'b0011, exp_seq: 4'b1100, hold_after: 0, hold_len: 0, inject: 1, exp_done: 5};

        bus1.Data_IN = '0; bus1.Data_Valid = 1'b0;
        bus3.Data_IN = '0; bus3.Data_Valid = 1'b0;

        // Reset state
        #12;
        check("rst_shift_en", se1, 0);
        check("rst_serial", sd1, 0);
        check("rst_done", done1, 0);
        check("rst_busy", busy1, 0);
        check("rst_ready", bus1.Data_Ready, 1);
        check("rst_bit_count", bc1, 0);
        check("rst_ready_div3", bus3.Data_Ready, 1);
        @(negedge clk); #2 rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Prescaler: DIV=3, word 0110
        begin
            int k, n, dc;
            int sc[4];
            logic [WIDTH-1:0] seq;
            k = 0; n = 0; dc = -1; seq = '0;
            for (int j = 0; j < 4; j++) sc[j] = -1;
            @(negedge clk);
            bus3.Data_IN = 4'b0110; bus3.Data_Valid = 1'b1;
            @(posedge clk); #1 bus3.Data_Valid = 1'b0;
            while (dc < 0 && k < 60) begin
                @(negedge clk);
                k++;
                if (se3) begin
                    if (n < 4) sc[n] = k;
                    n++;
                    seq = {seq[WIDTH-2:0], sd3};
                end
                if (done3) dc = k;
            end
            check("div3_shift1_cycle", sc[0], 3);
            check("div3_shift2_cycle", sc[1], 6);
            check("div3_shift3_cycle", sc[2], 9);
            check("div3_shift4_cycle", sc[3], 12);
            check("div3_shift_count", n, 4);
            check("div3_done_cycle", dc, 13);
            check("div3_serial_seq", seq, 4'b0110);
            check("div3_reg_q", q3, 4'b0110);
            check("div3_bit_count", bc3, 4);
        end

        // Handshake: Data_Valid held high with 4'hA then 4'h5
        begin
            int base, k;
            bit seen_done;
            base = acc_cyc.size();
            @(negedge clk);
            bus1.Data_IN = 4'hA; bus1.Data_Valid = 1'b1;
            k = 0;
            while (acc_cyc.size() <= base && k < 20) begin
                @(posedge clk); #1; k++;
            end
            bus1.Data_IN = 4'h5;
            k = 0;
            while (acc_cyc.size() <= base + 1 && k < 20) begin
                @(posedge clk); #1; k++;
            end
            bus1.Data_Valid = 1'b0;
            if (acc_cyc.size() >= base + 2) begin
                check("hs_interval", acc_cyc[base+1] - acc_cyc[base], 6);
                check("hs_first_word", acc_dat[base], 4'hA);
                check("hs_second_word", acc_dat[base+1], 4'h5);
            end else begin
                check("hs_accepts", acc_cyc.size() - base, 2);
            end
            seen_done = 1'b0; k = 0;
            while (!seen_done && k < 20) begin
                @(negedge clk); k++;
                if (done1) seen_done = 1'b1;
            end
            check("hs_done_seen", seen_done, 1);
            check("hs_reg_q", q1, 4'h5);
        end

        // Reset mid-word, asserted between clock edges after the 2nd shift
        begin
            int k, n, dones;
            k = 0; n = 0; dones = 0;
            @(negedge clk);
            bus1.Data_IN = 4'h6; bus1.Data_Valid = 1'b1;
            @(posedge clk); #1 bus1.Data_Valid = 1'b0;
            while (n < 2 && k < 20) begin
                @(negedge clk); k++;
                if (se1) n++;
            end
            check("mid_reset_reached_shift2", n, 2);
            @(posedge clk); #3 rst_n = 1'b0;
            #1;
            check("mid_reset_shift_en", se1, 0);
            check("mid_reset_busy", busy1, 0);
            check("mid_reset_done", done1, 0);
            check("mid_reset_ready", bus1.Data_Ready, 1);
            check("mid_reset_bit_count", bc1, 0);
            @(negedge clk); #2 rst_n = 1'b1;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                if (done1 || se1) dones++;
            end
            check("post_reset_no_activity", dones, 0);
            apply_vec("post_reset", '{data: 4'h9, exp_seq: 4'b1001, hold_after: 0,
                                     hold_len: 0, inject: 0, exp_done: 5});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
